// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: operand width, multiply FSM states and RV32M funct3 decoding.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALUOP_MUL = 3'b111;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mul_state_e;

    // Encodings 1xx are not multiplies; they fall back to plain MUL behaviour.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return f3 != MULHU_F3;
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 != MULHU_F3) && (f3 != MULHSU_F3);
    endfunction

    function automatic logic selects_low_half(input logic [2:0] f3);
        return f3[2] || (f3 == MUL_F3);
    endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath on operand magnitudes, with a final sign fix-up.
// Sequenced entirely by the load/step/fix strobes from mul_sequencer.
module mul_shift_add_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              fix_i,
    input  logic              a_signed_i,
    input  logic              b_signed_i,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    output logic [2*XLEN-1:0] product_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              neg_q, neg_d;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] fixed;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sign_a  = a_signed_i & op_a_i[XLEN-1];
        sign_b  = b_signed_i & op_b_i[XLEN-1];
        mag_a   = sign_a ? -op_a_i : op_a_i;
        mag_b   = sign_b ? -op_b_i : op_b_i;
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        fixed   = neg_q ? -acc_q : acc_q;

        acc_d   = acc_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        if (load_i) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = mag_b;
            neg_d   = sign_a ^ sign_b;
        end else if (step_i) begin
            // The carry out of the upper-half add becomes the new MSB after the shift.
            acc_d = {sum, acc_q[XLEN-1:1]};
        end else if (fix_i) begin
            acc_d = fixed;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
        end
    end

    assign product_o = fixed;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: stalls the pipeline for 32 shift-add steps plus a sign fix,
// then presents the selected product half with a one-cycle done pulse.
module mul_sequencer #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int ITERS = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [2:0]      out_funct3
);

    import alu_pkg::*;

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_STEP = CW'(ITERS - 1);

    mul_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        out_f3_q, out_f3_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              load, step, fix;
    logic [2*XLEN-1:0] product;

    mul_shift_add_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .fix_i     (fix),
        .a_signed_i(a_is_signed(funct3)),
        .b_signed_i(b_is_signed(funct3)),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .product_o (product)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        f3_d     = f3_q;
        out_f3_d = out_f3_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stall   = 1'b1;
                    load    = 1'b1;
                    f3_d    = funct3;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                stall   = 1'b1;
                step    = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                stall    = 1'b1;
                fix      = 1'b1;
                result_d = selects_low_half(f3_q) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                out_f3_d = f3_q;
                state_d  = DONE;
            end
            DONE: begin
                // A start still high here belongs to the instruction being released.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything: no load, no result update, no done, pipeline free to move.
        if (flush) begin
            state_d  = IDLE;
            count_d  = '0;
            f3_d     = f3_q;
            out_f3_d = out_f3_q;
            result_d = result_q;
            load     = 1'b0;
            step     = 1'b0;
            fix      = 1'b0;
            stall    = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            f3_q     <= '0;
            out_f3_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            f3_q     <= f3_d;
            out_f3_q <= out_f3_d;
            result_q <= result_d;
        end
    end

    assign result     = result_q;
    assign out_funct3 = out_f3_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed RV32M corner cases, flush/reset aborts,
// back-to-back issue and randomized operations against a 64-bit arithmetic reference.
module tb_mul_sequencer;

    localparam int XLEN = 32;
    localparam int LAT  = 34;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [2:0]      out_funct3;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [XLEN-1:0] exp_result;
    logic [2:0]      exp_f3;

    always #5 clk = ~clk;

    mul_sequencer #(.XLEN(XLEN), .ITERS(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .out_funct3(out_funct3)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // Reference: sign/zero extend to 64 bits, multiply, pick the half RV32M asks for.
    function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [63:0] ea, eb, p;
        bit          sa, sb;
        sa = (f3 != 3'b011);
        sb = (f3 != 3'b011) && (f3 != 3'b010);
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f3 == 3'b000 || f3[2]) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(5, 0))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one multiply in cycle 0 and checks stall/done/result every cycle through cycle 34.
    // Returns just after the edge that opens cycle 35, so a following call issues back-to-back.
    task automatic run_mul(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit noise);
        logic [XLEN-1:0] want_res;
        logic [2:0]      want_f3;
        flush  = 1'b0;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        for (int cyc = 0; cyc <= LAT; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (stall !== (cyc < LAT) || done !== (cyc == LAT)) begin
                tests_failed++;
                $display("FAIL %s cycle %0d stall/done: got %b/%b, want %b/%b",
                         name, cyc, stall, done, (cyc < LAT), (cyc == LAT));
            end
            want_res = (cyc == LAT) ? exp : exp_result;
            want_f3  = (cyc == LAT) ? f3 : exp_f3;
            tests_run++;
            if (result !== want_res || out_funct3 !== want_f3) begin
                tests_failed++;
                $display("FAIL %s cycle %0d result/funct3: got %h/%b, want %h/%b",
                         name, cyc, result, out_funct3, want_res, want_f3);
            end
            tick();
            if (noise && cyc < LAT) begin
                start  = 1'($urandom_range(1, 0));
                funct3 = 3'($urandom);
                op_a   = $urandom;
                op_b   = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        exp_result = exp;
        exp_f3     = f3;
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1 || stall !== 1'b0) pulses++;
            tick();
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL %s idle watch: got %0d cycles with done/stall active, want 0", name, pulses);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset stall/done: got %b/%b, want 0/0", stall, done);
        end
        tests_run++;
        if (result !== 32'h0 || out_funct3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset result/funct3: got %h/%b, want 0/000", result, out_funct3);
        end
        #1 start = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_comb_stall: got %b, want 1", stall);
        end
        start = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_start_stall: got %b, want 0", stall);
        end
        exp_result = '0;
        exp_f3     = 3'b000;
        tick();
    endtask

    task automatic test_directed();
        run_mul("mul_7x6",          3'b000, 32'd7,          32'd6,          32'h0000_002A, 1'b0); tick();
        run_mul("mul_neg3x5",       3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0); tick();
        run_mul("mulh_neg3x5",      3'b001, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 1'b0); tick();
        run_mul("mulh_min_sq",      3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 1'b0); tick();
        run_mul("mul_min_sq",       3'b000, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b0); tick();
        run_mul("mulhu_max",        3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0); tick();
        run_mul("mulhsu_neg1x2",    3'b010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 1'b0); tick();
        run_mul("f3_1xx_as_mul",    3'b101, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 1'b0); tick();
    endtask

    task automatic test_flush();
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            start = (cyc == 0);
            flush = (cyc == 10);
            @(negedge clk);
            tests_run++;
            if (stall !== (cyc < 10) || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush cycle %0d stall/done: got %b/%b, want %b/0", cyc, stall, done, (cyc < 10));
            end
            tick();
        end
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== exp_result || out_funct3 !== exp_f3) begin
            tests_failed++;
            $display("FAIL flush_idle: got stall=%b done=%b result=%h f3=%b, want 0 0 %h %b",
                     stall, done, result, out_funct3, exp_result, exp_f3);
        end
        tick();
        run_mul("restart_after_flush", 3'b000, 32'd9, 32'd9, 32'd81, 1'b0);
        tick();
    endtask

    task automatic test_flush_priority();
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'b011;
        op_a   = 32'h1234_5678;
        op_b   = 32'h9ABC_DEF0;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_priority stall: got %b, want 0", stall);
        end
        tick();
        start = 1'b0;
        flush = 1'b0;
        watch_no_done("flush_priority", 40);
    endtask

    task automatic test_reset_mid_op();
        flush  = 1'b0;
        funct3 = 3'b011;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'h1357_9BDF;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            start = (cyc == 0);
            rst_n = (cyc != 20);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid stall/done: got %b/%b, want 0/0", stall, done);
        end
        tests_run++;
        if (result !== 32'h0 || out_funct3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid result/funct3: got %h/%b, want 0/000", result, out_funct3);
        end
        exp_result = '0;
        exp_f3     = 3'b000;
        tick();
        watch_no_done("reset_mid", 40);
    endtask

    task automatic test_back_to_back();
        run_mul("b2b_first_noisy", 3'b000, 32'd123, 32'hFFFF_FF00, ref_mul(3'b000, 32'd123, 32'hFFFF_FF00), 1'b1);
        run_mul("b2b_second",      3'b001, 32'h7FFF_FFFF, 32'h8000_0000,
                ref_mul(3'b001, 32'h7FFF_FFFF, 32'h8000_0000), 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [2:0]      f3;
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(7, 0));
            a  = pick_operand();
            b  = pick_operand();
            run_mul($sformatf("rand_%0d", i), f3, a, b, ref_mul(f3, a, b), 1'($urandom_range(1, 0)));
            repeat ($urandom_range(2, 0)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_flush_priority();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle multiply controller for the execute stage.
- Triggered by the ALU `multiply` flag, which the ALU raises when ALUop = 3'b111.
- While the operation runs, it stalls the pipeline and computes the product with a radix-2 shift-add engine over 32 iterations, then returns the selected 32-bit half with a one-cycle done pulse.
- This replaces the unused single-cycle multiply megafunction path, keeping the ALU critical path short.

Parameters:
- XLEN, 32, operand and result width.
- ITERS, XLEN, shift-add iterations; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low; clears all state on a clk edge while low.
- start  in  1  ALU multiply flag qualified by a valid execute-stage instruction.
- flush  in  1  pipeline flush: aborts the current operation.
- funct3  in  3  multiply variant, per RV32M: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- op_a  in  XLEN  rs1 value (x1).
- op_b  in  XLEN  rs2 value (x2).
- stall  out  1  hold IF/ID/EX pipeline registers.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  selected product half.
- out_funct3  out  3  latched funct3, forwarded to EX/MEM.

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE, count = 0, result = 0, out_funct3 = 0.
  - Internal accumulator and multiplicand = 0.
  - done = 0; stall = 0 unless start is high in IDLE.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start = 1, capture operands, funct3 and sign flags; go to CALC with count = 0.
  - Signedness from funct3:
    - op_a signed for MUL, MULH and MULHSU.
    - op_b signed for MUL and MULH.
    - funct3 1xx is treated as MUL.
  - Load magnitudes: |op_a| if signed and negative, else op_a; likewise for op_b.
  - neg = sign_a XOR sign_b, each sign flag gated by its signedness.
- CALC, once per cycle for count = 0..31:
  - If multiplier LSB = 1, add the multiplicand to the upper half of the 64-bit accumulator, keeping the carry.
  - Then shift the {carry, accumulator} right by 1.
  - After count = 31, go to FIX.
- FIX:
  - If neg, take the 64-bit two's complement of the accumulator.
  - Latch result = low 32 bits for MUL, else high 32 bits.
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle; go to IDLE.
  - start is ignored here: it is the same instruction being released.
- Latency, with start first sampled in cycle 0:
  - CALC occupies cycles 1-32, FIX cycle 33, DONE cycle 34.
  - done is high in cycle 34 only.
  - Back-to-back multiply: earliest next start is sampled in cycle 35.
- stall = (IDLE and start) or CALC or FIX.
  - Combinational from start in IDLE; registered otherwise.
  - stall = 0 in DONE so the pipeline advances and captures the result.
- result and out_funct3 hold their value until the next FIX; they are never cleared except by reset.
- start while CALC or FIX is busy: ignored, no restart.
- flush:
  - In any state, the next state is IDLE with count = 0; no done is issued.
  - result keeps its prior value.
  - flush has priority over start in the same cycle; stall = 0 in a flush cycle.
- Reset mid-operation: identical to a power-on reset; no done.
- Overflow: none. The full 64-bit product is always formed and truncated only by the half-select.
- Edge case: 0x80000000 × 0x80000000 signed gives magnitude 2^62 with neg = 0, which is correct.

Decomposition:
- Package alu_pkg:
  - XLEN.
  - State enum {IDLE, CALC, FIX, DONE}.
  - funct3 constants MUL_F3, MULH_F3, MULHSU_F3, MULHU_F3.
  - ALUOP_MUL = 3'b111.
- Sub-module mul_shift_add_core:
  - Holds the accumulator, multiplicand, iteration step and final negate.
  - Controlled by load/step/fix strobes from the mul_sequencer FSM.

Test Plan:
- MUL 7 × 6, start held in cycle 0 -> stall cycles 0-33, done only in cycle 34, result = 0x0000002A, out_funct3 = 000.
- MUL -3 (0xFFFFFFFD) × 5 -> result = 0xFFFFFFF1; the same operands with MULH -> 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 -> result = 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result = 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- flush in cycle 10 of MUL 9 × 9 -> IDLE in cycle 11, no done, result unchanged; new MUL 9 × 9 started in cycle 12 -> done in cycle 46, result = 81.
- rst_n low in cycle 20 mid-op -> next cycle: state IDLE, result 0, done 0, stall 0 with start low.
- start toggled with different operands during CALC -> ignored; the original product is returned at cycle 34. Back-to-back MUL starting in cycle 35 -> done at cycle 69.
